board_mem_arbiter: RTL and testbench



---
 rtl/board_mem_arbiter.sv | 116 +++++++++++
 tb/tb_board_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
// Shares the single-port Game of Life board RAM between the display fetch, the generation engine
// and the init/copy writer. It also routes read data back by owner tag and counts contention stalls.
module board_mem_arbiter #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               disp_req,
    input  logic [ADDR_W-1:0]  disp_addr,
    output logic               disp_rvalid,
    output logic               disp_rdata,
    input  logic               eng_req,
    input  logic               eng_we,
    input  logic [ADDR_W-1:0]  eng_addr,
    input  logic               eng_wdata,
    output logic               eng_gnt,
    output logic               eng_rvalid,
    output logic               eng_rdata,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic               wr_wdata,
    output logic               wr_gnt,
    input  logic               freeze,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_wdata,
    input  logic               mem_rdata,
    output logic [STALL_W-1:0] stall_cnt,
    input  logic               stall_clr
);

    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagDisp = 2'd1,
        TagEng  = 2'd2
    } tag_e;

    logic               rr_q;
    tag_e               tag_q, tag_d;
    logic [STALL_W-1:0] stall_q;
    logic               disp_win, eng_v, wr_v, stall_event;

    // The display always wins; eng/wr are also masked by freeze. Everything is gated by reset.
    always_comb begin
        disp_win = rst_n & disp_req;
        eng_v    = rst_n & eng_req & ~freeze & ~disp_req;
        wr_v     = rst_n & wr_req & ~freeze & ~disp_req;
        eng_gnt  = eng_v & (~wr_v | ~rr_q);
        wr_gnt   = wr_v & (~eng_v | rr_q);
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 1'b0;
        if (disp_win) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (eng_gnt) begin
            mem_en    = 1'b1;
            mem_we    = eng_we;
            mem_addr  = eng_addr;
            mem_wdata = eng_wdata;
        end else if (wr_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_wdata;
        end
    end

    always_comb begin
        tag_d = TagNone;
        if (disp_win) begin
            tag_d = TagDisp;
        end else if (eng_gnt && !eng_we) begin
            tag_d = TagEng;
        end
    end

    assign stall_event = (eng_req | wr_req) & ~eng_gnt & ~wr_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            tag_q   <= TagNone;
            stall_q <= '0;
        end else begin
            if (eng_gnt) begin
                rr_q <= 1'b1;
            end else if (wr_gnt) begin
                rr_q <= 1'b0;
            end
            tag_q <= tag_d;
            if (stall_clr) begin
                stall_q <= '0;
            end else if (stall_event && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    // Read data returns one cycle after the access, to whoever the tag names.
    always_comb begin
        disp_rvalid = (tag_q == TagDisp);
        eng_rvalid  = (tag_q == TagEng);
        disp_rdata  = disp_rvalid & mem_rdata;
        eng_rdata   = eng_rvalid & mem_rdata;
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural board RAM and a narrow stall counter.
module tb_board_mem_arbiter;

    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned STALL_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               disp_req = 1'b0;
    logic [ADDR_W-1:0]  disp_addr = '0;
    logic               disp_rvalid, disp_rdata;
    logic               eng_req = 1'b0, eng_we = 1'b0, eng_wdata = 1'b0;
    logic [ADDR_W-1:0]  eng_addr = '0;
    logic               eng_gnt, eng_rvalid, eng_rdata;
    logic               wr_req = 1'b0, wr_wdata = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic               wr_gnt;
    logic               freeze = 1'b0;
    logic               mem_en, mem_we, mem_wdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rdata = 1'b0;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    board_mem_arbiter #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_wdata(wr_wdata), .wr_gnt(wr_gnt),
        .freeze(freeze),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    // Board RAM with one-cycle read latency; preloaded on its first clock edge.
    bit ram [0:2047];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            ram[11'h3C0] <= 1'b1;
            ram[11'h010] <= 1'b1;
            ram_init     <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int exp_cnt;
        // Power-on reset
        tick(); tick();
        settle();
        chk("por_mem_en", mem_en, 0);
        chk("por_stall", stall_cnt, 0);
        rst_n = 1'b1;

        // Display priority over a full three-way collision
        disp_req = 1'b1; disp_addr = 11'h07F;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 11'h010;
        wr_req = 1'b1; wr_addr = 11'h020; wr_wdata = 1'b1;
        settle();
        chk("disp_mem_addr", mem_addr, 11'h07F);
        chk("disp_mem_en", mem_en, 1);
        chk("disp_mem_we", mem_we, 0);
        chk("disp_eng_gnt", eng_gnt, 0);
        chk("disp_wr_gnt", wr_gnt, 0);
        tick();
        disp_req = 1'b0;
        settle();
        chk("disp_rvalid", disp_rvalid, 1);
        chk("disp_rdata", disp_rdata, 0);
        chk("disp_stall", stall_cnt, 1);
        // Round robin: eng, wr, eng, wr starting from rr=0
        chk("rr0_eng_gnt", eng_gnt, 1);
        chk("rr0_wr_gnt", wr_gnt, 0);
        chk("rr0_mem_addr", mem_addr, 11'h010);
        tick();
        chk("rr1_eng_rvalid", eng_rvalid, 1);
        chk("rr1_eng_rdata", eng_rdata, 1);
        chk("rr1_disp_rvalid", disp_rvalid, 0);
        chk("rr1_wr_gnt", wr_gnt, 1);
        chk("rr1_eng_gnt", eng_gnt, 0);
        chk("rr1_mem_we", mem_we, 1);
        chk("rr1_mem_addr", mem_addr, 11'h020);
        tick();
        chk("rr2_eng_rvalid", eng_rvalid, 0);
        chk("rr2_eng_gnt", eng_gnt, 1);
        chk("rr2_mem_we", mem_we, 0);
        tick();
        chk("rr3_eng_rvalid", eng_rvalid, 1);
        chk("rr3_wr_gnt", wr_gnt, 1);
        chk("rr3_mem_we", mem_we, 1);
        eng_req = 1'b0; wr_req = 1'b0;
        tick();
        chk("rr_done_eng_rvalid", eng_rvalid, 0);
        chk("rr_done_stall", stall_cnt, 1);
        chk("rr_ram_written", 32'(ram[11'h020]), 1);

        // Read data routing: display at N, engine (stalled) at N+1
        disp_req = 1'b1; disp_addr = 11'h3C0;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 11'h3C0;
        settle();
        chk("route_eng_blocked", eng_gnt, 0);
        tick();
        disp_req = 1'b0;
        settle();
        chk("route_disp_rvalid", disp_rvalid, 1);
        chk("route_disp_rdata", disp_rdata, 1);
        chk("route_eng_rdata_n1", eng_rdata, 0);
        chk("route_eng_gnt", eng_gnt, 1);
        chk("route_stall", stall_cnt, 2);
        tick();
        chk("route_eng_rvalid", eng_rvalid, 1);
        chk("route_eng_rdata", eng_rdata, 1);
        chk("route_disp_rvalid_n2", disp_rvalid, 0);
        chk("route_disp_rdata_n2", disp_rdata, 0);
        // Lone engine write with rr=1 is still granted at once, and gives no rvalid
        eng_we = 1'b1; eng_addr = 11'h001; eng_wdata = 1'b1;
        settle();
        chk("lone_eng_gnt", eng_gnt, 1);
        chk("lone_mem_we", mem_we, 1);
        tick();
        chk("lone_no_rvalid", eng_rvalid, 0);
        chk("lone_ram_written", 32'(ram[11'h001]), 1);

        // Freeze blocks the engine; the 4-bit counter saturates
        freeze = 1'b1; eng_we = 1'b0; eng_addr = 11'h3C0;
        exp_cnt = 2;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("frz_eng_gnt", eng_gnt, 0);
            chk("frz_mem_en", mem_en, 0);
            tick();
            if (exp_cnt < 15) exp_cnt++;
            chk("frz_stall", stall_cnt, exp_cnt);
        end
        chk("frz_saturated", stall_cnt, 15);
        stall_clr = 1'b1;
        tick();
        chk("clr_stall", stall_cnt, 0);
        stall_clr = 1'b0; freeze = 1'b0;
        settle();
        chk("unfrz_eng_gnt", eng_gnt, 1);
        tick();
        chk("unfrz_stall", stall_cnt, 0);
        chk("unfrz_eng_rvalid", eng_rvalid, 1);

        // Reset mid-stream with everything requesting; a pending display rvalid is lost
        disp_req = 1'b1; disp_addr = 11'h3C0; wr_req = 1'b1;
        tick();
        chk("pre_rst_disp_rvalid", disp_rvalid, 1);
        chk("pre_rst_stall", stall_cnt, 1);
        rst_n = 1'b0;
        settle();
        chk("rst_disp_rvalid", disp_rvalid, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_eng_gnt", eng_gnt, 0);
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_stall", stall_cnt, 0);
        tick();
        settle();
        chk("rst_hold_mem_en", mem_en, 0);
        chk("rst_hold_stall", stall_cnt, 0);
        disp_req = 1'b0;
        rst_n = 1'b1;
        settle();
        chk("post_rst_eng_gnt", eng_gnt, 1);
        chk("post_rst_wr_gnt", wr_gnt, 0);
        tick();
        chk("post_rst_wr_turn", wr_gnt, 1);
        eng_req = 1'b0; wr_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
